ervp_platform_proc_tracker: RTL



---
 rtl/ervp_platform_controller_pkg.sv | 12 +
 rtl/ervp_core_stall_monitor.sv | 23 ++
 rtl/ervp_platform_proc_tracker.sv | 73 +++++++
 3 files changed

// File: rtl/ervp_platform_controller_pkg.sv
// ervp_platform_controller_pkg: shared encodings and constants for the platform controller
package ervp_platform_controller_pkg;
  typedef enum logic [1:0] {
    INIT_WAIT_CLAIM = 2'd0,
    INIT_WAIT_BOOT  = 2'd1,
    INIT_DONE       = 2'd2
  } init_state_e;
  localparam logic [31:0] AUTOID_NONE = 32'hFFFF_FFFF;
  localparam int CLAIMED_LSB = 0;
  localparam int STALLED_LSB = 16;
  localparam logic [31:0] DEFAULT_BOOT_DONE_CODE = 32'h0000_0001;
endpackage

// File: rtl/ervp_core_stall_monitor.sv
// ervp_core_stall_monitor: flags a claimed core whose PC has not changed for STALL_CYCLES cycles
module ervp_core_stall_monitor #(
  parameter int STALL_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic        enable,
  input  logic [31:0] pc,
  output logic        stalled
);
  localparam int CW = $clog2(STALL_CYCLES + 1);
  logic [31:0]   pc_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      pc_q <= '0;
      cnt  <= '0;
    end else begin
      pc_q <= pc;
      cnt  <= (!enable || pc != pc_q) ? '0 : (stalled ? cnt : cnt + 1'b1);
    end
  assign stalled = (cnt == CW'(STALL_CYCLES));
endmodule

// File: rtl/ervp_platform_proc_tracker.sv
// ervp_platform_proc_tracker: core auto-ID, claim/stall status and boot-init tracking (stall monitors under PLATFORM_PROC_STALL_MONITOR_EN)
module ervp_platform_proc_tracker
  import ervp_platform_controller_pkg::*;
#(
  parameter int          NUM_CORE       = 4,
  parameter int          STALL_CYCLES   = 1024,
  parameter logic [31:0] BOOT_DONE_CODE = DEFAULT_BOOT_DONE_CODE
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  autoid_rd,
  output logic [31:0]           autoid_rdata,
  output logic [31:0]           status_rdata,
  input  logic                  boot_status_wr,
  input  logic [31:0]           boot_status_wdata,
  output logic [31:0]           boot_status_rdata,
  input  logic [32*NUM_CORE-1:0] core_pc,
  output logic                  initialized,
  output logic                  all_claimed
);
  localparam int IW = $clog2(NUM_CORE + 1);
  logic [IW-1:0]       next_id;
  logic [31:0]         boot_status;
  logic [NUM_CORE-1:0] claimed;
  logic [NUM_CORE-1:0] stalled;
  init_state_e         state;
  assign all_claimed       = (next_id == IW'(NUM_CORE));
  assign autoid_rdata      = all_claimed ? AUTOID_NONE : 32'(next_id);
  assign boot_status_rdata = boot_status;
  always_comb begin
    status_rdata = '0;
    status_rdata[CLAIMED_LSB +: NUM_CORE] = claimed;
    status_rdata[STALLED_LSB +: NUM_CORE] = stalled;
  end
  genvar g;
  generate
    for (g = 0; g < NUM_CORE; g++) begin : g_claim
      assign claimed[g] = (next_id > IW'(g));
    end
  endgenerate
`ifdef PLATFORM_PROC_STALL_MONITOR_EN
  generate
    for (g = 0; g < NUM_CORE; g++) begin : g_mon
      ervp_core_stall_monitor #(.STALL_CYCLES(STALL_CYCLES)) u_mon (
        .clk     (clk),
        .rstnn   (rstnn),
        .enable  (claimed[g]),
        .pc      (core_pc[32*(g+1)-1 -: 32]),
        .stalled (stalled[g])
      );
    end
  endgenerate
`else
  logic unused_core_pc;
  assign unused_core_pc = ^core_pc;
  assign stalled = '0;
`endif
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      next_id     <= '0;
      boot_status <= '0;
      state       <= INIT_WAIT_CLAIM;
      initialized <= 1'b0;
    end else begin
      if (autoid_rd && !all_claimed) next_id <= next_id + 1'b1;
      if (boot_status_wr) boot_status <= boot_status_wdata;
      if (state == INIT_WAIT_CLAIM && all_claimed) state <= INIT_WAIT_BOOT;
      if (state == INIT_WAIT_BOOT && boot_status_wr && boot_status_wdata == BOOT_DONE_CODE) begin
        state       <= INIT_DONE;
        initialized <= 1'b1;
      end
    end
endmodule
